// File: rtl/fp_div_iter.sv
// fp_div_iter: iterative floating-point divider (a / b), one operation in flight.
//   Radix-2 restoring mantissa recurrence, round-to-nearest-even, flush-to-zero
//   for subnormal inputs and underflowing results.
// Ports:
//   aclk, aresetn         clock; asynchronous reset, active-high despite the name
//   s_axis_a_*            dividend {sign, exp, frac}, tuser sideband sampled with it
//   s_axis_b_*            divisor; both operands are taken in one joint handshake
//   m_axis_result_*       quotient with its tuser, held stable under backpressure
//   flag                  {invalid, div_by_zero, overflow, underflow, inexact}
module fp_div_iter #(
    parameter int EXP     = 5,
    parameter int FRA     = 10,
    parameter int TUSER_W = 4
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic [EXP+FRA:0]   s_axis_a_tdata,
    input  logic               s_axis_a_tvalid,
    output logic               s_axis_a_tready,
    input  logic [TUSER_W-1:0] s_axis_a_tuser,
    input  logic [EXP+FRA:0]   s_axis_b_tdata,
    input  logic               s_axis_b_tvalid,
    output logic               s_axis_b_tready,
    output logic [EXP+FRA:0]   m_axis_result_tdata,
    output logic               m_axis_result_tvalid,
    input  logic               m_axis_result_tready,
    output logic [TUSER_W-1:0] m_axis_result_tuser,
    output logic [4:0]         flag
);
    localparam int W    = EXP + FRA + 1;
    localparam int N    = FRA + 3;
    localparam int EW   = EXP + 2;
    localparam int CW   = $clog2(N);
    localparam int BIAS = (1 << (EXP - 1)) - 1;
    localparam int EMAX = (1 << EXP) - 1;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP{1'b1}}, 1'b1, {(FRA-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM, S_OUT} state_t;

    state_t               state_q, state_d;
    logic                 tready_q, tready_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [FRA+2:0]       rem_q, rem_d;
    logic [FRA:0]         mb_q, mb_d;
    // The leading quotient bit is always 1 after pre-alignment, so only the
    // bits below it are kept: FRA fraction bits, guard, round.
    logic [FRA+1:0]       quo_q, quo_d;
    logic signed [EW-1:0] e_q, e_d;
    logic                 sign_q, sign_d;
    logic                 special_q, special_d;
    logic [W-1:0]         spec_data_q, spec_data_d;
    logic [4:0]           spec_flag_q, spec_flag_d;
    logic [TUSER_W-1:0]   user_q, user_d;
    logic [W-1:0]         out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic [TUSER_W-1:0]   out_user_q, out_user_d;
    logic [4:0]           flag_q, flag_d;

    logic [EXP-1:0] ea, eb;
    logic [FRA-1:0] fa, fb;
    logic           s_ab;
    logic           a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [FRA:0]   ma, mb;
    logic           a_lt;
    logic           accept;
    logic           is_special;
    logic [W-1:0]   spec_data;
    logic [4:0]     spec_flag;
    logic           rem_ge;
    logic [FRA+2:0] rem_sub;
    logic           g_bit, r_bit, st_bit, rnd_up;
    logic [FRA:0]   frac_sum;
    int             e_int;

    always_comb begin
        // unpack
        ea     = s_axis_a_tdata[W-2:FRA];
        eb     = s_axis_b_tdata[W-2:FRA];
        fa     = s_axis_a_tdata[FRA-1:0];
        fb     = s_axis_b_tdata[FRA-1:0];
        s_ab   = s_axis_a_tdata[W-1] ^ s_axis_b_tdata[W-1];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (ea == '1) && (fa == '0);
        b_inf  = (eb == '1) && (fb == '0);
        a_nan  = (ea == '1) && (fa != '0);
        b_nan  = (eb == '1) && (fb != '0);
        ma     = {1'b1, fa};
        mb     = {1'b1, fb};
        a_lt   = (ma < mb);

        // special-operand results; inf/0 counts as inf/finite, so inf_a wins over zero_b
        is_special = 1'b1;
        spec_data  = '0;
        spec_flag  = '0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_data = QNAN;
            spec_flag = 5'b10000;
        end else if (a_inf) begin
            spec_data = {s_ab, {EXP{1'b1}}, {FRA{1'b0}}};
        end else if (b_zero) begin
            spec_data = {s_ab, {EXP{1'b1}}, {FRA{1'b0}}};
            spec_flag = 5'b01000;
        end else if (a_zero || b_inf) begin
            spec_data = {s_ab, {(W-1){1'b0}}};
        end else begin
            is_special = 1'b0;
        end

        // one recurrence step
        rem_ge  = (rem_q >= {2'b00, mb_q});
        rem_sub = rem_ge ? (rem_q - {2'b00, mb_q}) : rem_q;

        // rounding: a carry out of the fraction means the mantissa reached 2.0;
        // the fraction field is then already zero and only the exponent moves
        g_bit    = quo_q[1];
        r_bit    = quo_q[0];
        st_bit   = (rem_q != '0);
        rnd_up   = g_bit & (r_bit | st_bit | quo_q[2]);
        frac_sum = {1'b0, quo_q[FRA+1:2]} + {{FRA{1'b0}}, rnd_up};
        e_int    = int'(e_q) + int'(frac_sum[FRA]);

        accept = (state_q == S_IDLE) && tready_q && s_axis_a_tvalid && s_axis_b_tvalid;

        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        mb_d        = mb_q;
        quo_d       = quo_q;
        e_d         = e_q;
        sign_d      = sign_q;
        special_d   = special_q;
        spec_data_d = spec_data_q;
        spec_flag_d = spec_flag_q;
        user_d      = user_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_user_d  = out_user_q;
        flag_d      = flag_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    sign_d      = s_ab;
                    user_d      = s_axis_a_tuser;
                    special_d   = is_special;
                    spec_data_d = spec_data;
                    spec_flag_d = spec_flag;
                    // pre-align so the quotient lies in [1, 2)
                    rem_d       = a_lt ? {1'b0, ma, 1'b0} : {2'b00, ma};
                    mb_d        = mb;
                    e_d         = EW'(ea) - EW'(eb) + EW'(BIAS) - EW'(a_lt);
                    cnt_d       = '0;
                    quo_d       = '0;
                    state_d     = is_special ? S_NORM : S_DIV;
                end
            end
            S_DIV: begin
                rem_d = rem_sub << 1;
                quo_d = {quo_q[FRA:0], rem_ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                out_user_d  = user_q;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
                if (special_q) begin
                    out_data_d = spec_data_q;
                    flag_d     = spec_flag_q;
                end else if (e_int >= EMAX) begin
                    out_data_d = {sign_q, {EXP{1'b1}}, {FRA{1'b0}}};
                    flag_d     = 5'b00101;
                end else if (e_int <= 0) begin
                    out_data_d = {sign_q, {(W-1){1'b0}}};
                    flag_d     = 5'b00011;
                end else begin
                    out_data_d = {sign_q, EXP'(e_int), frac_sum[FRA-1:0]};
                    flag_d     = {4'b0000, g_bit | r_bit | st_bit};
                end
            end
            S_OUT: begin
                if (m_axis_result_tready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        tready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            state_q     <= S_IDLE;
            tready_q    <= 1'b0;
            cnt_q       <= '0;
            rem_q       <= '0;
            mb_q        <= '0;
            quo_q       <= '0;
            e_q         <= '0;
            sign_q      <= 1'b0;
            special_q   <= 1'b0;
            spec_data_q <= '0;
            spec_flag_q <= '0;
            user_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_user_q  <= '0;
            flag_q      <= '0;
        end else begin
            state_q     <= state_d;
            tready_q    <= tready_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            mb_q        <= mb_d;
            quo_q       <= quo_d;
            e_q         <= e_d;
            sign_q      <= sign_d;
            special_q   <= special_d;
            spec_data_q <= spec_data_d;
            spec_flag_q <= spec_flag_d;
            user_q      <= user_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_user_q  <= out_user_d;
            flag_q      <= flag_d;
        end
    end

    assign s_axis_a_tready      = tready_q;
    assign s_axis_b_tready      = tready_q;
    assign m_axis_result_tdata  = out_data_q;
    assign m_axis_result_tvalid = out_valid_q;
    assign m_axis_result_tuser  = out_user_q;
    assign flag                 = flag_q;

endmodule

// File: tb/tb_fp_div_iter.sv
// Testbench for fp_div_iter in FP16 (EXP=5, FRA=10): fixed vectors, protocol
// sequences (backpressure, lone valid, mid-operation reset) and random operands
// against an exact-arithmetic reference quotient.
module tb_fp_div_iter;
    localparam int EXP     = 5;
    localparam int FRA     = 10;
    localparam int TUSER_W = 4;

    logic        aclk    = 1'b0;
    logic        aresetn = 1'b1;
    logic [15:0] a_data  = '0;
    logic [15:0] b_data  = '0;
    logic        a_valid = 1'b0;
    logic        b_valid = 1'b0;
    logic [3:0]  a_user  = '0;
    logic        a_ready, b_ready;
    logic [15:0] r_data;
    logic        r_valid;
    logic        r_ready = 1'b0;
    logic [3:0]  r_user;
    logic [4:0]  flag;

    int tests = 0;
    int fails = 0;

    always #5 aclk = ~aclk;

    fp_div_iter #(.EXP(EXP), .FRA(FRA), .TUSER_W(TUSER_W)) dut (
        .aclk                 (aclk),
        .aresetn              (aresetn),
        .s_axis_a_tdata       (a_data),
        .s_axis_a_tvalid      (a_valid),
        .s_axis_a_tready      (a_ready),
        .s_axis_a_tuser       (a_user),
        .s_axis_b_tdata       (b_data),
        .s_axis_b_tvalid      (b_valid),
        .s_axis_b_tready      (b_ready),
        .m_axis_result_tdata  (r_data),
        .m_axis_result_tvalid (r_valid),
        .m_axis_result_tready (r_ready),
        .m_axis_result_tuser  (r_user),
        .flag                 (flag)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  u;
        int          hold;
        logic [15:0] d;
        logic [4:0]  f;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Exact reference: the significand quotient is formed with 40 extra bits
    // and rounded by comparing the discarded part with one half.
    function automatic void ref_div(input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] d, output logic [4:0] f, output int lat);
        int ea, eb, e, sh;
        longint unsigned ma, mb, num, q, r, m, low, half;
        bit s, up, inx, za, zb, ia, ib, na, nb;
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        s  = a[15] ^ b[15];
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 31) && (a[9:0] == 0);
        ib = (eb == 31) && (b[9:0] == 0);
        na = (ea == 31) && (a[9:0] != 0);
        nb = (eb == 31) && (b[9:0] != 0);
        f   = '0;
        lat = 2;
        d   = '0;
        if (na || nb || (za && zb) || (ia && ib)) begin
            d = 16'h7E00;
            f = 5'b10000;
        end else if (ia) begin
            d = {s, 15'h7C00};
        end else if (zb) begin
            d = {s, 15'h7C00};
            f = 5'b01000;
        end else if (za || ib) begin
            d = {s, 15'h0000};
        end else begin
            lat  = 15;
            ma   = 64'(a[9:0]) + 64'd1024;
            mb   = 64'(b[9:0]) + 64'd1024;
            num  = ma << 40;
            q    = num / mb;
            r    = num % mb;
            e    = ea - eb + 15;
            if (q >= (64'd1 << 40)) sh = 30;
            else begin
                sh = 29;
                e  = e - 1;
            end
            m    = q >> sh;
            low  = q & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            up   = (low > half) || ((low == half) && ((r != 0) || m[0]));
            inx  = (low != 0) || (r != 0);
            if (up) m = m + 64'd1;
            if (m == 64'd2048) begin
                m = 64'd1024;
                e = e + 1;
            end
            if (e >= 31) begin
                d = {s, 15'h7C00};
                f = 5'b00101;
            end else if (e <= 0) begin
                d = {s, 15'h0000};
                f = 5'b00011;
            end else begin
                d = {s, 5'(e), 10'(m)};
                f = {4'b0000, inx};
            end
        end
    endfunction

    // One full transaction: joint handshake, latency count, optional hold of
    // m_tready low for `hold` cycles, then a single transfer.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] u, input int hold,
                         output logic [15:0] d, output logic [4:0] f, output logic [3:0] uo, output int lat);
        int  wait_n;
        bit  stable;
        d = '0; f = '0; uo = '0; lat = 0;
        @(negedge aclk);
        a_data = a; b_data = b; a_user = u;
        a_valid = 1'b1; b_valid = 1'b1; r_ready = 1'b0;
        wait_n = 0;
        while (!(a_ready && b_ready) && wait_n < 50) begin
            @(negedge aclk);
            wait_n++;
        end
        if (!(a_ready && b_ready)) begin
            check("accept_timeout", 0, 1);
            a_valid = 1'b0; b_valid = 1'b0;
            return;
        end
        @(posedge aclk);
        #1;
        a_valid = 1'b0; b_valid = 1'b0;
        a_data = 16'($urandom); b_data = 16'($urandom); a_user = 4'($urandom);
        check("tready_drop", {30'b0, a_ready, b_ready}, 0);
        lat = 1;
        while (!r_valid && lat < 100) begin
            @(posedge aclk);
            #1;
            lat++;
        end
        if (!r_valid) begin
            check("result_timeout", 0, 1);
            return;
        end
        d = r_data; f = flag; uo = r_user;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge aclk);
            #1;
            if (r_data !== d || flag !== f || r_user !== uo || r_valid !== 1'b1 ||
                a_ready !== 1'b0 || b_ready !== 1'b0) stable = 1'b0;
        end
        if (hold > 0) check("hold_stable", {31'b0, stable}, 1);
        r_ready = 1'b1;
        @(posedge aclk);
        #1;
        r_ready = 1'b0;
        check("post_xfer", {29'b0, r_valid, a_ready, b_ready}, 3'b011);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[14];
        logic [15:0] d, ed, ra, rb;
        logic [4:0]  f, ef;
        logic [3:0]  uo, ru;
        int          lat, elat;
        bit          seen_drop, seen_valid, stale;

        vecs[0]  = '{16'h3266, 16'h2E66, 4'h5, 0, 16'h4000, 5'h00, 15};
        vecs[1]  = '{16'h3C00, 16'h4200, 4'h1, 0, 16'h3555, 5'h01, 15};
        vecs[2]  = '{16'h3C00, 16'h0000, 4'h2, 0, 16'h7C00, 5'h08, 2};
        vecs[3]  = '{16'h0000, 16'h0000, 4'h3, 0, 16'h7E00, 5'h10, 2};
        vecs[4]  = '{16'h7C00, 16'hFC00, 4'h4, 0, 16'h7E00, 5'h10, 2};
        vecs[5]  = '{16'h7BFF, 16'h3800, 4'h6, 0, 16'h7C00, 5'h05, 15};
        vecs[6]  = '{16'h0400, 16'h4000, 4'h7, 0, 16'h0000, 5'h03, 15};
        vecs[7]  = '{16'hBC00, 16'h4000, 4'h8, 0, 16'hB800, 5'h00, 15};
        vecs[8]  = '{16'h7C00, 16'h3C00, 4'h9, 0, 16'h7C00, 5'h00, 2};
        vecs[9]  = '{16'h3C00, 16'h7C00, 4'hA, 0, 16'h0000, 5'h00, 2};
        vecs[10] = '{16'h0000, 16'hBC00, 4'hB, 0, 16'h8000, 5'h00, 2};
        vecs[11] = '{16'h7D00, 16'h3C00, 4'hC, 0, 16'h7E00, 5'h10, 2};
        vecs[12] = '{16'hFC00, 16'h0000, 4'hD, 0, 16'hFC00, 5'h00, 2};
        vecs[13] = '{16'h3C00, 16'h4200, 4'hE, 5, 16'h3555, 5'h01, 15};

        // reset state
        aresetn = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_out", {4'b0, r_valid, a_ready, b_ready, r_data, r_user, flag}, 0);
        @(negedge aclk);
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        check("tready_rise", {30'b0, a_ready, b_ready}, 2'b11);

        // fixed vectors; the last one holds m_tready low for 5 cycles
        for (int i = 0; i < 14; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].u, vecs[i].hold, d, f, uo, lat);
            check($sformatf("vec%0d_data", i), {16'b0, d}, {16'b0, vecs[i].d});
            check($sformatf("vec%0d_flag", i), {27'b0, f}, {27'b0, vecs[i].f});
            check($sformatf("vec%0d_user", i), {28'b0, uo}, {28'b0, vecs[i].u});
            check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
        end

        // lone a_tvalid must not be accepted
        seen_drop = 1'b0;
        seen_valid = 1'b0;
        @(negedge aclk);
        a_data = 16'h3C00; a_valid = 1'b1; b_valid = 1'b0;
        repeat (6) begin
            @(posedge aclk);
            #1;
            if (!a_ready || !b_ready) seen_drop = 1'b1;
        end
        a_valid = 1'b0;
        repeat (20) begin
            @(posedge aclk);
            #1;
            if (r_valid) seen_valid = 1'b1;
        end
        check("lone_valid", {30'b0, seen_drop, seen_valid}, 0);

        // reset pulse while the recurrence is running
        @(negedge aclk);
        a_data = 16'h3266; b_data = 16'h2E66; a_user = 4'h9;
        a_valid = 1'b1; b_valid = 1'b1;
        @(posedge aclk);
        #1;
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (5) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        check("rst_mid", {4'b0, r_valid, a_ready, b_ready, r_data, r_user, flag}, 0);
        @(negedge aclk);
        aresetn = 1'b0;
        stale = 1'b0;
        repeat (20) begin
            @(posedge aclk);
            #1;
            if (r_valid) stale = 1'b1;
        end
        check("no_stale", {31'b0, stale}, 0);
        do_op(16'h3266, 16'h2E66, 4'h3, 0, d, f, uo, lat);
        check("fresh_data", {16'b0, d}, 32'h4000);
        check("fresh_flag", {27'b0, f}, 0);
        check("fresh_user", {28'b0, uo}, 4'h3);
        check("fresh_lat", lat, 15);

        // random operands against the reference
        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            ru = 4'($urandom);
            if (i % 2 == 0) begin
                ra[14:10] = 5'(13 + $urandom_range(0, 4));
                rb[14:10] = 5'(13 + $urandom_range(0, 4));
            end
            ref_div(ra, rb, ed, ef, elat);
            do_op(ra, rb, ru, int'($urandom_range(0, 2)), d, f, uo, lat);
            check($sformatf("rnd%0d_data a=%h b=%h", i, ra, rb), {16'b0, d}, {16'b0, ed});
            check($sformatf("rnd%0d_flag a=%h b=%h", i, ra, rb), {27'b0, f}, {27'b0, ef});
            check($sformatf("rnd%0d_user", i), {28'b0, uo}, {28'b0, ru});
            check($sformatf("rnd%0d_lat", i), lat, elat);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
